// File: rtl/soc_dac_capture.sv
// Triggered capture buffer for the core DAC output stream.
// Keeps PRE samples of history ahead of a trigger and DEPTH-PRE samples from the
// trigger onward. The capture is read back oldest-first once it is complete.
module soc_dac_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned PRE    = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              core_clk,
    input  logic              core_reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_value,
    input  logic              trig_ext,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              armed,
    output logic              triggered,
    output logic              done
);

    localparam int unsigned CW        = AW + 1;
    localparam int unsigned POST_N    = DEPTH - PRE;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_N - 1);
    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE);

    typedef enum logic [2:0] {
        StIdle,
        StPrefill,
        StWaitTrig,
        StPost,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     start_ptr_q, start_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              trig_q, trig_d;
    logic [DATA_W-1:0] rd_q;
    logic              wr_en;
    logic              trig_hit;
    logic [AW-1:0]     rd_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    // Trigger condition for the sample currently on sample_in.
    always_comb begin
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'b00: trig_hit = 1'b1;
            2'b01: trig_hit = (sample_in == trig_value);
            2'b10: trig_hit = (prev_q <= trig_value) && (sample_in > trig_value);
            2'b11: trig_hit = trig_ext;
        endcase
    end

    // Next-state logic: abort wins over arm and trigger.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        trig_d      = trig_q;
        wr_en       = 1'b0;
        if (abort) begin
            state_d = StIdle;
            trig_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_d  = StPrefill;
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        trig_d   = 1'b0;
                    end
                end
                StPrefill: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        prev_d   = sample_in;
                        if (cnt_q == PRE_LAST) begin
                            state_d = StWaitTrig;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                StWaitTrig: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        prev_d   = sample_in;
                        if (trig_hit) begin
                            // Oldest retained sample sits PRE writes behind the trigger.
                            start_ptr_d = wr_ptr_q - PRE_OFF;
                            trig_d      = 1'b1;
                            cnt_d       = CW'(1);
                            state_d     = (POST_LAST == '0) ? StDone : StPost;
                        end
                    end
                end
                StPost: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        prev_d   = sample_in;
                        if (cnt_q == POST_LAST) begin
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control/status registers with synchronous active-low reset.
    always_ff @(posedge core_clk) begin
        if (!core_reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            trig_q      <= trig_d;
        end
    end

    // Sample storage; contents are not reset.
    always_ff @(posedge core_clk) begin
        if (core_reset && wr_en) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    assign rd_idx = start_ptr_q + rd_addr;

    // Registered readout relative to the oldest captured sample.
    always_ff @(posedge core_clk) begin
        if (!core_reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_idx];
        end
    end

    assign rd_data   = (state_q == StDone) ? rd_q : '0;
    assign armed     = (state_q == StPrefill) || (state_q == StWaitTrig) || (state_q == StPost);
    assign triggered = trig_q;
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_soc_dac_capture.sv
// Directed bench for soc_dac_capture (DATA_W=8, DEPTH=16, PRE=4).
// A stream-level model records every accepted sample since arm; the expected
// readout is the DEPTH-sample window starting PRE samples before the trigger.
module tb_soc_dac_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic          core_clk;
    logic          core_reset;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          arm;
    logic          abort;
    logic [1:0]    trig_mode;
    logic [DW-1:0] trig_value;
    logic          trig_ext;
    logic [3:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          armed;
    logic          triggered;
    logic          done;

    soc_dac_capture #(.DATA_W(DW), .DEPTH(DEPTH), .PRE(PRE)) dut (
        .core_clk     (core_clk),
        .core_reset   (core_reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_value   (trig_value),
        .trig_ext     (trig_ext),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .armed        (armed),
        .triggered    (triggered),
        .done         (done)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int total = 0;
    int bad   = 0;

    // Model: ph 0 idle, 1 prefill, 2 wait, 3 post, 4 done.
    int            ph = 0;
    int            mcnt = 0;
    int            trig_at = 0;
    logic [DW-1:0] mprev = '0;
    logic [DW-1:0] cap[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model using the inputs the DUT samples at the coming edge.
    task automatic model_edge();
        logic hit;
        if (!core_reset) begin
            ph = 0;
            mcnt = 0;
            mprev = '0;
            return;
        end
        if (abort) begin
            ph = 0;
        end else if (arm && (ph == 0 || ph == 4)) begin
            ph = 1;
            mcnt = 0;
            cap.delete();
        end else if (sample_valid && ph >= 1 && ph <= 3) begin
            cap.push_back(sample_in);
            if (ph == 1) begin
                mcnt++;
                if (mcnt == PRE) ph = 2;
            end else if (ph == 2) begin
                case (trig_mode)
                    2'b00:   hit = 1'b1;
                    2'b01:   hit = (sample_in == trig_value);
                    2'b10:   hit = (mprev <= trig_value) && (sample_in > trig_value);
                    default: hit = trig_ext;
                endcase
                if (hit) begin
                    trig_at = cap.size() - 1;
                    mcnt = 1;
                    ph = (mcnt == DEPTH - PRE) ? 4 : 3;
                end
            end else begin
                mcnt++;
                if (mcnt == DEPTH - PRE) ph = 4;
            end
            mprev = sample_in;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge core_clk);
        #1;
        chk("armed", armed, (ph >= 1 && ph <= 3));
        chk("triggered", triggered, (ph >= 3));
        chk("done", done, (ph == 4));
        if (ph != 4) chk("rd_data_zero", rd_data, 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v, input logic e);
        sample_in = d;
        sample_valid = v;
        trig_ext = e;
        step();
        sample_valid = 1'b0;
        trig_ext = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic readall(input string tag);
        logic [DW-1:0] got;
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = 4'(k);
            exp_q.push_back(cap[trig_at - PRE + k]);
            step();
            got = exp_q.pop_front();
            chk(tag, rd_data, got);
        end
    endtask

    task automatic rd_one(input string tag, input int k, input logic [DW-1:0] lit);
        rd_addr = 4'(k);
        step();
        chk(tag, rd_data, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        core_reset = 1'b0;
        sample_in = '0;
        sample_valid = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        trig_mode = 2'b00;
        trig_value = '0;
        trig_ext = 1'b0;
        rd_addr = '0;

        // Reset state.
        step();
        step();
        chk("rst_armed", armed, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", rd_data, 0);
        core_reset = 1'b1;
        step();

        // Immediate trigger on a ramp.
        trig_mode = 2'b00;
        do_arm();
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1, 1'b0);
            if (i == 3) chk("imm_pre_untrig", triggered, 0);
            if (i == 4) chk("imm_trig_on_4", triggered, 1);
        end
        chk("imm_done", done, 1);
        readall("imm_rd");
        rd_one("imm_rd15", 15, 8'h0F);

        // Equal trigger; the 0x11 inside prefill must not fire.
        trig_mode = 2'b01;
        trig_value = 8'h11;
        do_arm();
        send(8'h11, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        chk("eq_prefill_untrig", triggered, 0);
        for (int v = 8'h0D; v <= 8'h1C; v++) send(8'(v), 1'b1, 1'b0);
        readall("eq_rd");
        rd_one("eq_rd0", 0, 8'h0D);
        rd_one("eq_rd4", 4, 8'h11);
        rd_one("eq_rd15", 15, 8'h1C);

        // Rising threshold crossing.
        trig_mode = 2'b10;
        trig_value = 8'h80;
        do_arm();
        send(8'h90, 1'b1, 1'b0);
        send(8'h70, 1'b1, 1'b0);
        send(8'h70, 1'b1, 1'b0);
        send(8'h70, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0);
        chk("thr_no_trig_eq", triggered, 0);
        send(8'h81, 1'b1, 1'b0);
        chk("thr_trig_81", triggered, 1);
        for (int v = 8'h82; v <= 8'h8C; v++) send(8'(v), 1'b1, 1'b0);
        readall("thr_rd");
        rd_one("thr_rd4", 4, 8'h81);

        // External trigger with valid gaps; trig_ext held high on invalid cycles.
        begin
            int nv;
            nv = 0;
            trig_mode = 2'b11;
            do_arm();
            for (int i = 0; i < 100 && ph != 4; i++) begin
                if (i % 2 == 0) begin
                    send(8'(8'h30 + nv), 1'b1, (nv == 20));
                    nv++;
                end else begin
                    send(8'hEE, 1'b0, 1'b1);
                end
            end
            chk("gap_done", done, 1);
            readall("gap_rd");
            rd_one("gap_rd4", 4, 8'h44);
            rd_one("gap_rd0", 0, 8'h40);
        end

        // Abort together with arm in POST.
        trig_mode = 2'b00;
        do_arm();
        for (int i = 0; i < 6; i++) send(8'(8'h50 + i), 1'b1, 1'b0);
        chk("abort_pre_post", triggered, 1);
        abort = 1'b1;
        arm = 1'b1;
        sample_in = 8'h56;
        sample_valid = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b0;
        sample_valid = 1'b0;
        chk("abort_armed", armed, 0);
        chk("abort_trig", triggered, 0);
        chk("abort_done", done, 0);
        step();

        // Reset in POST, then a clean capture.
        do_arm();
        for (int i = 0; i < 6; i++) send(8'(8'h58 + i), 1'b1, 1'b0);
        core_reset = 1'b0;
        arm = 1'b1;
        sample_valid = 1'b1;
        step();
        arm = 1'b0;
        sample_valid = 1'b0;
        chk("rst2_armed", armed, 0);
        chk("rst2_trig", triggered, 0);
        chk("rst2_rd", rd_data, 0);
        core_reset = 1'b1;
        step();
        do_arm();
        for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b1, 1'b0);
        chk("post_rst_done", done, 1);
        readall("post_rst_rd");
        rd_one("post_rst_rd4", 4, 8'h64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
